// File: rtl/pim_pkg.sv
// pim_pkg: command opcodes and FSM state encodings shared by the PIM MAC sequencer.
package pim_pkg;
  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_MAC     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WRITE    = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_READ_CAP = 3'd3;
  localparam logic [2:0] S_MAC      = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_CAPTURE  = 3'd6;
  localparam logic [2:0] S_RESP     = 3'd7;
endpackage

// File: rtl/pim_mac_sequencer.sv
// pim_mac_sequencer: sequences WRITE/READ/MAC commands onto a PIM array and returns one response each.
// Optional PIM_SEQ_PERF_EN adds perf_mac_cnt / perf_busy_cnt counters.
import pim_pkg::*;
module pim_mac_sequencer #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16,
  parameter int PWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [PWIDTH-1:0] cmd_wdata,
  input  logic [4:0]        cmd_bits,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] pim_addr,
  output logic [PWIDTH-1:0] pim_d,
  output logic              pim_w_en,
  output logic              pim_p_en,
  input  logic [PWIDTH-1:0] pim_q,
  input  logic [DWIDTH-1:0] pim_mac_out
`ifdef PIM_SEQ_PERF_EN
  ,output logic [31:0]      perf_mac_cnt,
  output logic [31:0]       perf_busy_cnt
`endif
);
  logic [2:0]        r_state, w_next;
  logic [5:0]        r_cnt;
  logic [AWIDTH-1:0] r_addr;
  logic [PWIDTH-1:0] r_d;
  logic [DWIDTH-1:0] r_data;
  logic              r_err, r_is_mac, w_accept;
  assign cmd_ready = r_state == S_IDLE;
  assign w_accept  = cmd_valid && cmd_ready;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign pim_addr  = r_addr;
  assign pim_d     = r_d;
  assign pim_w_en  = r_state == S_WRITE;
  assign pim_p_en  = r_state == S_MAC;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid)
                    w_next = cmd_op == OP_WRITE ? S_WRITE :
                             cmd_op == OP_READ  ? S_READ  :
                             cmd_op == OP_MAC   ? S_MAC   : S_RESP;
      S_WRITE:    w_next = S_RESP;
      S_READ:     w_next = S_READ_CAP;
      S_READ_CAP: w_next = S_RESP;
      S_MAC:      w_next = r_cnt == 6'd1 ? S_DRAIN : S_MAC;
      S_DRAIN:    w_next = S_CAPTURE;
      S_CAPTURE:  w_next = S_RESP;
      S_RESP:     w_next = rsp_ready ? S_IDLE : S_RESP;
      default:    w_next = S_IDLE;
    endcase
  end
  // 6-bit count so cmd_bits=0 loads 32 without wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_d      <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_is_mac <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt    <= cmd_bits == 5'd0 ? 6'd32 : {1'b0, cmd_bits};
        r_data   <= '0;
        r_err    <= cmd_op == OP_ILLEGAL;
        r_is_mac <= cmd_op == OP_MAC;
        if (cmd_op == OP_WRITE || cmd_op == OP_READ) r_addr <= cmd_addr;
        if (cmd_op == OP_WRITE) r_d <= cmd_wdata;
      end
      if (r_state == S_MAC) r_cnt <= r_cnt - 6'd1;
      if (r_state == S_READ_CAP) r_data <= DWIDTH'(pim_q);
      if (r_state == S_CAPTURE) r_data <= pim_mac_out;
    end
  end
`ifdef PIM_SEQ_PERF_EN
  logic [31:0] r_perf_mac, r_perf_busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_mac  <= '0;
      r_perf_busy <= '0;
    end else begin
      if (r_state != S_IDLE) r_perf_busy <= r_perf_busy + 32'd1;
      if (r_state == S_RESP && rsp_ready && r_is_mac) r_perf_mac <= r_perf_mac + 32'd1;
    end
  end
  assign perf_mac_cnt  = r_perf_mac;
  assign perf_busy_cnt = r_perf_busy;
`endif
endmodule

// File: tb/tb_pim_mac_sequencer.sv
// tb_pim_mac_sequencer: directed checks of the PIM MAC sequencer against a small behavioural PIM array.
module tb_pim_mac_sequencer;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int PW = 32;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [PW-1:0] cmd_wdata = '0;
  logic [4:0]    cmd_bits = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] pim_addr;
  logic [PW-1:0] pim_d, pim_q;
  logic          pim_w_en, pim_p_en;
  logic [DW-1:0] pim_mac_out, acc;
  logic [PW-1:0] mem [0:15];
  int n_w = 0, n_p = 0, n_both = 0;
  int n_chk = 0, n_fail = 0;
  int lat, w0, p0;
  logic c1_w, c1_p;
  logic [AW-1:0] c1_addr;
  logic [PW-1:0] c1_d;
  pim_mac_sequencer #(.DWIDTH(DW), .AWIDTH(AW), .PWIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_bits(cmd_bits),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pim_addr(pim_addr), .pim_d(pim_d), .pim_w_en(pim_w_en), .pim_p_en(pim_p_en),
    .pim_q(pim_q), .pim_mac_out(pim_mac_out)
  );
  always #5 clk = ~clk;
  // PIM array: sync read, +3 per MAC cycle, result registered and accumulator cleared when p_en drops
  always @(posedge clk) begin
    if (pim_w_en) mem[pim_addr[3:0]] <= pim_d;
    pim_q <= mem[pim_addr[3:0]];
    if (pim_p_en) acc <= acc + 64'd3;
    else begin
      pim_mac_out <= acc;
      acc <= '0;
    end
    if (pim_w_en) n_w++;
    if (pim_p_en) n_p++;
    if (pim_w_en && pim_p_en) n_both++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [PW-1:0] wd, input logic [4:0] b);
    w0 = n_w;
    p0 = n_p;
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_bits = b; cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c1_w = pim_w_en; c1_p = pim_p_en; c1_addr = pim_addr; c1_d = pim_d;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic handshake();
    rsp_ready = 1'b1;
    chk("cmd_ready_in_resp", cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_w_en", pim_w_en, 0);
    chk("rst_p_en", pim_p_en, 0);
    chk("rst_addr", pim_addr, 0);
    chk("rst_d", pim_d, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_post_rst", cmd_ready, 1);
    issue(2'b00, 16'h0005, 32'hA5A5A5A5, 5'd0);
    chk("wr_c1_w_en", c1_w, 1);
    chk("wr_c1_p_en", c1_p, 0);
    chk("wr_c1_addr", c1_addr, 16'h0005);
    chk("wr_c1_d", c1_d, 32'hA5A5A5A5);
    chk("wr_latency", lat, 2);
    chk("wr_data", rsp_data, 0);
    chk("wr_err", rsp_err, 0);
    handshake();
    chk("wr_w_cycles", n_w - w0, 1);
    issue(2'b01, 16'h0005, 32'h0, 5'd0);
    chk("rd_c1_w_en", c1_w, 0);
    chk("rd_latency", lat, 3);
    chk("rd_data", rsp_data, 64'h00000000A5A5A5A5);
    chk("rd_err", rsp_err, 0);
    handshake();
    chk("rd_addr_held", pim_addr, 16'h0005);
    issue(2'b10, 16'h0000, 32'h0, 5'd4);
    chk("mac4_latency", lat, 7);
    chk("mac4_data", rsp_data, 64'd12);
    chk("mac4_err", rsp_err, 0);
    handshake();
    chk("mac4_p_cycles", n_p - p0, 4);
    chk("mac4_w_cycles", n_w - w0, 0);
    chk("mac4_addr_held", pim_addr, 16'h0005);
    issue(2'b10, 16'h0000, 32'h0, 5'd0);
    chk("mac32_latency", lat, 35);
    chk("mac32_data", rsp_data, 64'd96);
    handshake();
    chk("mac32_p_cycles", n_p - p0, 32);
    issue(2'b11, 16'h0003, 32'hFFFFFFFF, 5'd7);
    chk("ill_latency", lat, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_data", rsp_data, 0);
    handshake();
    chk("ill_w_cycles", n_w - w0, 0);
    chk("ill_p_cycles", n_p - p0, 0);
    chk("ill_addr_held", pim_addr, 16'h0005);
    issue(2'b00, 16'h0009, 32'h12345678, 5'd0);
    chk("stall_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, 0);
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    handshake();
    issue(2'b01, 16'h0009, 32'h0, 5'd0);
    chk("b2b_rd_latency", lat, 3);
    chk("b2b_rd_data", rsp_data, 64'h0000000012345678);
    handshake();
    cmd_op = 2'b10; cmd_bits = 5'd8; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_p_en_c2", pim_p_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_p_en", pim_p_en, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) lat++;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", lat, 0);
    issue(2'b01, 16'h0005, 32'h0, 5'd0);
    chk("post_abort_rd_latency", lat, 3);
    chk("post_abort_rd_data", rsp_data, 64'h00000000A5A5A5A5);
    handshake();
    issue(2'b10, 16'h0000, 32'h0, 5'd4);
    chk("post_abort_mac_data", rsp_data, 64'd12);
    handshake();
    chk("never_both_en", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
